// File: rtl/line_window_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : line_window_buffer_if
// Description : Pixel stream in / windowed taps out bundle for
//               line_window_buffer. The slave modport is the buffer side,
//               the master modport is the source/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface line_window_buffer_if #(
  parameter int CHANNELS   = 3,
  parameter int COLORDEPTH = 8,
  parameter int LINES      = 3
);
  logic [CHANNELS*COLORDEPTH-1:0]       data_i;
  logic                                 dv_i;
  logic                                 hs_i;
  logic                                 vs_i;
  logic                                 dv_o;
  logic                                 hs_o;
  logic                                 vs_o;
  logic [LINES*CHANNELS*COLORDEPTH-1:0] taps_o;
  logic [LINES-1:0]                     tap_valid_o;
  logic                                 ovf_o;

  modport slave (
    input  data_i, dv_i, hs_i, vs_i,
    output dv_o, hs_o, vs_o, taps_o, tap_valid_o, ovf_o
  );

  modport master (
    output data_i, dv_i, hs_i, vs_i,
    input  dv_o, hs_o, vs_o, taps_o, tap_valid_o, ovf_o
  );
endinterface
`default_nettype wire

// File: rtl/line_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_window_buffer
// Description : Sliding multi-line buffer. Presents the current pixel plus
//               the co-located pixels of the previous LINES-1 active lines,
//               one cycle after the input, with per-frame tap validity and a
//               sticky line-overflow flag.
//               Optional macro BORDER_REPLICATE_EN: invalid taps repeat the
//               nearest valid tap below them (edge replication at frame top).
// Revision    : 1.0 - initial release
// ============================================================================
module line_window_buffer #(
  parameter int CHANNELS    = 3,
  parameter int COLORDEPTH  = 8,
  parameter int SCREENWIDTH = 1600,
  parameter int LINES       = 3,
  parameter int ADDR_W      = 11
) (
  input  wire logic             clk,
  input  wire logic             rst,   // asynchronous, active-low
  line_window_buffer_if.slave   bus
);

  localparam int PIX_W = CHANNELS * COLORDEPTH;
  localparam int NB    = LINES - 1;
  localparam int WP_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(SCREENWIDTH - 1);
  localparam logic [WP_W-1:0]   LAST_WP  = WP_W'(NB - 1);

  logic                          dv_q, hs_q, vs_q;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic                          full_q, full_d;   // last column already written this line
  logic [WP_W-1:0]               wp_q, wp_d;
  logic [LINES-1:0]              hist_q, hist_d;   // bit 0 unused, always 0
  logic                          ovf_q, ovf_d;
  logic [LINES-1:0][PIX_W-1:0]   taps_q, taps_d;

  logic                          line_end_w;
  logic                          frame_start_w;
  logic [NB-1:0][PIX_W-1:0]      bank_rd_w;
  logic [LINES-1:0][PIX_W-1:0]   tap_raw_w;
  logic [LINES-1:0][PIX_W-1:0]   tap_sel_w;

  assign line_end_w    = !bus.dv_i && dv_q;
  assign frame_start_w = bus.vs_i && !vs_q;

  // One RAM per stored line; the read is taken before this cycle's write
  // lands, so the oldest tap still sees the line about to be replaced.
  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [PIX_W-1:0] mem [SCREENWIDTH];

    // Write the incoming pixel into the bank currently owned by this line.
    always_ff @(posedge clk) begin
      if (bus.dv_i && (wp_q == WP_W'(b))) begin
        mem[addr_q] <= bus.data_i;
      end
    end

    assign bank_rd_w[b] = mem[addr_q];
  end

  // Map each tap to the bank holding the line k rows back.
  always_comb begin
    logic [WP_W-1:0] sel;
    tap_raw_w    = '0;
    tap_raw_w[0] = bus.data_i;
    for (int k = 1; k < LINES; k++) begin
      sel          = WP_W'((int'(wp_q) + NB * LINES - k) % NB);
      tap_raw_w[k] = bank_rd_w[sel];
    end
  end

`ifdef BORDER_REPLICATE_EN
  // Invalid taps repeat the nearest valid tap below them; validity is judged
  // against the history that will accompany these taps on the output.
  always_comb begin
    logic [PIX_W-1:0] fill;
    tap_sel_w    = '0;
    fill         = tap_raw_w[0];
    tap_sel_w[0] = tap_raw_w[0];
    for (int k = 1; k < LINES; k++) begin
      if (hist_d[k]) begin
        fill = tap_raw_w[k];
      end
      tap_sel_w[k] = fill;
    end
  end
`else
  // Invalid taps pass raw bank contents; consumers gate on tap_valid_o.
  always_comb begin
    tap_sel_w = tap_raw_w;
  end
`endif

  // Next-state logic for addressing, bank rotation, history and overflow.
  always_comb begin
    addr_d = '0;
    full_d = 1'b0;
    wp_d   = wp_q;
    hist_d = hist_q;
    ovf_d  = ovf_q;
    taps_d = taps_q;

    if (bus.dv_i) begin
      addr_d = (addr_q == LAST_COL) ? addr_q : addr_q + 1'b1;
      full_d = full_q || (addr_q == LAST_COL);
      taps_d = tap_sel_w;
      if (full_q) begin
        ovf_d = 1'b1;
      end
    end

    if (line_end_w) begin
      wp_d   = (wp_q == LAST_WP) ? '0 : wp_q + 1'b1;
      hist_d = ((hist_q << 1) | LINES'(2)) & ~LINES'(1);
    end

    // A new frame discards all history even if a line ends in the same cycle.
    if (frame_start_w) begin
      hist_d = '0;
      ovf_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dv_q   <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      addr_q <= '0;
      full_q <= 1'b0;
      wp_q   <= '0;
      hist_q <= '0;
      ovf_q  <= 1'b0;
      taps_q <= '0;
    end else begin
      dv_q   <= bus.dv_i;
      hs_q   <= bus.hs_i;
      vs_q   <= bus.vs_i;
      addr_q <= addr_d;
      full_q <= full_d;
      wp_q   <= wp_d;
      hist_q <= hist_d;
      ovf_q  <= ovf_d;
      taps_q <= taps_d;
    end
  end

  assign bus.dv_o        = dv_q;
  assign bus.hs_o        = hs_q;
  assign bus.vs_o        = vs_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.taps_o      = taps_q;
  assign bus.tap_valid_o = {hist_q[LINES-1:1] & {(LINES-1){dv_q}}, dv_q};

endmodule
`default_nettype wire
